// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch to imem,
// absorbs stalls/redirects and presents a fetched instruction or a NOP bubble to the F/D register.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetch_cnt / perf_wait_cnt outputs.
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h1000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_stall,
  output logic        fetch_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StHold  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] hold_q, hold_d;

  logic        req_w;
  logic [31:0] addr_w;
  logic        stall_w;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    req_w   = 1'b0;
    addr_w  = pc_q;
    stall_w = 1'b0;
    valid_w = 1'b0;
    instr_w = NOP_INSTR;
    pc_w    = pc_q;

    unique case (state_q)
      StFetch: begin
        req_w = 1'b1;
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            // Request cannot be withdrawn; remember the target and wait for the ack.
            tgt_d   = redirect_pc;
            state_d = StDrain;
            stall_w = 1'b1;
          end
        end else if (imem_ack) begin
          valid_w = 1'b1;
          instr_w = imem_rdata;
          if (stallF) begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else begin
          stall_w = 1'b1;
        end
      end

      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else begin
          valid_w = 1'b1;
          instr_w = hold_q;
          if (!stallF) begin
            pc_d    = pc_q + 32'd4;
            state_d = StFetch;
          end
        end
      end

      StDrain: begin
        req_w   = 1'b1;
        stall_w = 1'b1;
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_pc : tgt_q;
          state_d = StFetch;
        end else if (redirect_valid) begin
          tgt_d = redirect_pc;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset is synchronous, so outputs must look idle during the reset cycle itself.
    if (rst) begin
      req_w   = 1'b0;
      addr_w  = RESET_PC;
      stall_w = 1'b0;
      valid_w = 1'b0;
      instr_w = NOP_INSTR;
      pc_w    = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_req    = req_w;
  assign imem_addr   = addr_w;
  assign imem_stall  = stall_w;
  assign fetch_valid = valid_w;
  assign Instr       = instr_w;
  assign PC          = pc_w;
  assign PC_plus4    = pc_w + 32'd4;
  assign opcode      = instr_w[6:0];
  assign funct3      = instr_w[14:12];
  assign funct7      = instr_w[31:25];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      wait_cnt_q  <= 32'h0;
    end else begin
      if (valid_w && !stallF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_w)            wait_cnt_q  <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule
